// File: rtl/iomem_debug_pkg.sv
// Shared types and constants for the iomem debug master: FSM state encoding,
// command opcodes and single-byte reply codes.
package iomem_debug_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'

  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'
  localparam logic [7:0] RSP_UNK   = 8'h3F;  // '?'

endpackage

// File: rtl/iomem_debug_txq.sv
// Reply queue: holds up to 4 reply bytes, presents them LSB first on the
// tx_valid/tx_ready handshake. Loaded in parallel with 1 or 4 bytes only
// while empty. 'done' pulses in the cycle the last byte is accepted.
module iomem_debug_txq (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        load_four,
  input  logic [31:0] load_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [23:0] shift_r;  // bytes still waiting behind tx_data
  logic [1:0]  left_r;   // number of bytes in shift_r

  assign done = tx_valid && tx_ready && (left_r == 2'd0);

  // Load a reply, then advance one byte per accepted handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      shift_r  <= 24'h000000;
      left_r   <= 2'd0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data[7:0];
      shift_r  <= load_data[31:8];
      left_r   <= load_four ? 2'd3 : 2'd0;
    end else if (tx_valid && tx_ready) begin
      if (left_r != 2'd0) begin
        tx_data <= shift_r[7:0];
        shift_r <= {8'h00, shift_r[23:8]};
        left_r  <= left_r - 2'd1;
      end else begin
        tx_valid <= 1'b0;
        tx_data  <= 8'h00;
      end
    end
  end

endmodule

// File: rtl/iomem_debug_master.sv
// Byte-command iomem bus initiator for bring-up: parses 'W'/'R' frames from
// a UART receiver, runs one 32-bit iomem transfer, and queues the reply.
// Optional feature macro: IOMEM_DEBUG_TIMEOUT_EN aborts a bus transfer that
// has waited TIMEOUT_CYCLES cycles and replies 'E'.
module iomem_debug_master
  import iomem_debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  state_t      state_r;
  logic [1:0]  cnt_r;
  logic        is_write_r;
  logic        txq_load_s;
  logic        txq_four_s;
  logic [31:0] txq_data_s;
  logic        txq_done_s;

`ifdef IOMEM_DEBUG_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_r;
`endif

  // Decide when and what to load into the reply queue.
  always_comb begin
    txq_load_s = 1'b0;
    txq_four_s = 1'b0;
    txq_data_s = 32'h00000000;
    case (state_r)
      IDLE: begin
        if (rx_valid && (rx_data != CMD_WRITE) && (rx_data != CMD_READ)) begin
          txq_load_s = 1'b1;
          txq_data_s = {24'h000000, RSP_UNK};
        end else begin
          txq_load_s = 1'b0;
        end
      end
      BUS: begin
        if (iomem_ready) begin
          txq_load_s = 1'b1;
          if (is_write_r) begin
            txq_data_s = {24'h000000, RSP_OK};
          end else begin
            txq_four_s = 1'b1;
            txq_data_s = iomem_rdata;
          end
`ifdef IOMEM_DEBUG_TIMEOUT_EN
        end else if (wait_r == WAIT_LAST) begin
          txq_load_s = 1'b1;
          txq_data_s = {24'h000000, RSP_ERR};
`endif
        end else begin
          txq_load_s = 1'b0;
        end
      end
      default: begin
        txq_load_s = 1'b0;
      end
    endcase
  end

  // Frame parser and bus FSM with registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      is_write_r  <= 1'b0;
      busy        <= 1'b0;
      iomem_valid <= 1'b0;
      iomem_wstrb <= 4'h0;
      iomem_addr  <= 32'h00000000;
      iomem_wdata <= 32'h00000000;
`ifdef IOMEM_DEBUG_TIMEOUT_EN
      wait_r      <= 16'h0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (rx_valid) begin
            busy  <= 1'b1;
            cnt_r <= 2'd0;
            if (rx_data == CMD_WRITE) begin
              is_write_r <= 1'b1;
              state_r    <= ADDR;
            end else if (rx_data == CMD_READ) begin
              is_write_r <= 1'b0;
              state_r    <= ADDR;
            end else begin
              state_r    <= RESP;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            cnt_r <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              // Final byte: word-align, the low two bits are dropped.
              iomem_addr <= {rx_data, iomem_addr[31:10], 2'b00};
              if (is_write_r) begin
                state_r <= DATA;
              end else begin
                state_r     <= BUS;
                iomem_valid <= 1'b1;
                iomem_wstrb <= 4'h0;
`ifdef IOMEM_DEBUG_TIMEOUT_EN
                wait_r      <= 16'h0000;
`endif
              end
            end else begin
              iomem_addr <= {rx_data, iomem_addr[31:8]};
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            cnt_r       <= cnt_r + 2'd1;
            iomem_wdata <= {rx_data, iomem_wdata[31:8]};
            if (cnt_r == 2'd3) begin
              state_r     <= BUS;
              iomem_valid <= 1'b1;
              iomem_wstrb <= 4'hF;
`ifdef IOMEM_DEBUG_TIMEOUT_EN
              wait_r      <= 16'h0000;
`endif
            end
          end
        end
        BUS: begin
          if (iomem_ready) begin
            iomem_valid <= 1'b0;
            state_r     <= RESP;
`ifdef IOMEM_DEBUG_TIMEOUT_EN
          end else if (wait_r == WAIT_LAST) begin
            iomem_valid <= 1'b0;
            state_r     <= RESP;
          end else begin
            wait_r <= wait_r + 16'd1;
`endif
          end
        end
        RESP: begin
          if (txq_done_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  iomem_debug_txq u_txq (
    .clk       (clk),
    .reset     (reset),
    .load      (txq_load_s),
    .load_four (txq_four_s),
    .load_data (txq_data_s),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .done      (txq_done_s)
  );

endmodule

// File: tb/tb_iomem_debug_master.sv
// Directed self-checking bench for iomem_debug_master (TIMEOUT_CYCLES=8).
module tb_iomem_debug_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  iomem_debug_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid"},   {31'd0, iomem_valid}, 32'd0);
    chk({tag, "_wstrb"},   {28'd0, iomem_wstrb}, 32'd0);
    chk({tag, "_addr"},    iomem_addr, 32'd0);
    chk({tag, "_wdata"},   iomem_wdata, 32'd0);
    chk({tag, "_txvalid"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_txdata"},  {24'd0, tx_data}, 32'd0);
    chk({tag, "_busy"},    {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] rd_bytes [4];
    int vcnt;
    rd_bytes[0] = 8'hEF; rd_bytes[1] = 8'hBE; rd_bytes[2] = 8'hAD; rd_bytes[3] = 8'hDE;

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    iomem_ready = 1'b0; iomem_rdata = 32'h0;
    step(); step();
    reset = 1'b0;
    all_zero("rst");

    // Write to GPIO, ready one cycle after valid.
    send(8'h57); send(8'h00); send(8'h00); send(8'h00); send(8'h03);
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    chk("wr_valid1", {31'd0, iomem_valid}, 32'd1);
    chk("wr_addr",   iomem_addr, 32'h03000000);
    chk("wr_wdata",  iomem_wdata, 32'h00000001);
    chk("wr_wstrb",  {28'd0, iomem_wstrb}, 32'hF);
    chk("wr_busy",   {31'd0, busy}, 32'd1);
    step();
    chk("wr_valid2", {31'd0, iomem_valid}, 32'd1);
    chk("wr_addr2",  iomem_addr, 32'h03000000);
    iomem_ready = 1'b1;
    step();
    iomem_ready = 1'b0;
    chk("wr_valid_low", {31'd0, iomem_valid}, 32'd0);
    chk("wr_txvalid",   {31'd0, tx_valid}, 32'd1);
    chk("wr_txdata",    {24'd0, tx_data}, 32'h4B);
    tx_ready = 1'b1;
    step();
    chk("wr_txdone", {31'd0, tx_valid}, 32'd0);
    chk("wr_idle",   {31'd0, busy}, 32'd0);

    // Read from timer, same-cycle ready, tx_ready held high.
    send(8'h52); send(8'h04); send(8'h00); send(8'h00); send(8'h06);
    chk("rd_valid", {31'd0, iomem_valid}, 32'd1);
    chk("rd_addr",  iomem_addr, 32'h06000004);
    chk("rd_wstrb", {28'd0, iomem_wstrb}, 32'h0);
    iomem_ready = 1'b1; iomem_rdata = 32'hDEADBEEF;
    step();
    iomem_ready = 1'b0; iomem_rdata = 32'h0;
    chk("rd_valid_low", {31'd0, iomem_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rd_txvalid", {31'd0, tx_valid}, 32'd1);
      chk("rd_byte",    {24'd0, tx_data}, {24'd0, rd_bytes[i]});
      step();
    end
    chk("rd_txdone", {31'd0, tx_valid}, 32'd0);
    chk("rd_idle",   {31'd0, busy}, 32'd0);

    // Same read with tx_ready toggling.
    tx_ready = 1'b0;
    send(8'h52); send(8'h04); send(8'h00); send(8'h00); send(8'h06);
    iomem_ready = 1'b1; iomem_rdata = 32'hDEADBEEF;
    step();
    iomem_ready = 1'b0; iomem_rdata = 32'h0;
    for (int i = 0; i < 8; i++) begin
      tx_ready = (i % 2 == 1);
      chk("bp_txvalid", {31'd0, tx_valid}, 32'd1);
      chk("bp_byte",    {24'd0, tx_data}, {24'd0, rd_bytes[i / 2]});
      step();
    end
    chk("bp_txdone", {31'd0, tx_valid}, 32'd0);
    chk("bp_idle",   {31'd0, busy}, 32'd0);

    // Unknown opcode.
    tx_ready = 1'b0;
    send(8'h00);
    chk("unk_txvalid", {31'd0, tx_valid}, 32'd1);
    chk("unk_txdata",  {24'd0, tx_data}, 32'h3F);
    chk("unk_novalid", {31'd0, iomem_valid}, 32'd0);
    tx_ready = 1'b1;
    step();
    chk("unk_txdone", {31'd0, tx_valid}, 32'd0);
    chk("unk_idle",   {31'd0, busy}, 32'd0);

    // Responder never answers.
    tx_ready = 1'b0;
    send(8'h52); send(8'h10); send(8'h00); send(8'h00); send(8'h06);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (iomem_valid) vcnt++;
      step();
    end
`ifdef IOMEM_DEBUG_TIMEOUT_EN
    chk("to_valid_cycles", vcnt, 32'd8);
    chk("to_txvalid",      {31'd0, tx_valid}, 32'd1);
    chk("to_txdata",       {24'd0, tx_data}, 32'h45);
    tx_ready = 1'b1;
    step();
    chk("to_txdone", {31'd0, tx_valid}, 32'd0);
    chk("to_idle",   {31'd0, busy}, 32'd0);
`else
    chk("to_valid_cycles", vcnt, 32'd20);
    chk("to_still_valid",  {31'd0, iomem_valid}, 32'd1);
    chk("to_no_tx",        {31'd0, tx_valid}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif

    // Reset during BUS.
    tx_ready = 1'b0;
    send(8'h57); send(8'h00); send(8'h00); send(8'h00); send(8'h04);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("rb_valid", {31'd0, iomem_valid}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    all_zero("rst_bus");

    // Reset during RESP.
    send(8'h52); send(8'h00); send(8'h00); send(8'h00); send(8'h05);
    iomem_ready = 1'b1; iomem_rdata = 32'h11223344;
    step();
    iomem_ready = 1'b0; iomem_rdata = 32'h0;
    chk("rr_txvalid", {31'd0, tx_valid}, 32'd1);
    chk("rr_txdata",  {24'd0, tx_data}, 32'h44);
    reset = 1'b1;
    step();
    reset = 1'b0;
    all_zero("rst_resp");

    // Write after reset, unaligned low address bits dropped.
    send(8'h57); send(8'h0B); send(8'h00); send(8'h00); send(8'h05);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("pw_addr",  iomem_addr, 32'h05000008);
    chk("pw_wdata", iomem_wdata, 32'h12345678);
    chk("pw_wstrb", {28'd0, iomem_wstrb}, 32'hF);
    iomem_ready = 1'b1;
    step();
    iomem_ready = 1'b0;
    chk("pw_txvalid", {31'd0, tx_valid}, 32'd1);
    chk("pw_txdata",  {24'd0, tx_data}, 32'h4B);
    tx_ready = 1'b1;
    step();
    chk("pw_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
